// File: rtl/data_ram.sv
// data_ram: slow data-memory responder for the MIPS32 memory stage.
// Word-organised storage with byte-lane write enables, big-endian lane order
// (sel bit 3 <-> data[31:24] <-> addr[1:0]=00), and WAIT_CYCLES wait states
// during which a stall request is raised to the pipeline controller.
// Optional feature macro: DATA_RAM_ALIGN_CHECK_EN enables misalignment
// detection (suppressed access plus sticky err_o); without it err_o is tied 0.
module data_ram #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_req_o,
  output logic        err_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_RELOAD = (WAIT_CYCLES >= 2) ? 4'(WAIT_CYCLES - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;
  logic [3:0] wait_cnt, wait_cnt_next;

  // request captured when a stalled access is accepted
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic [3:0]  lat_sel;
  logic        lat_we;
  logic        lat_mis;
  logic        latch_en;

  // the access being completed this cycle (live request or latched one)
  logic                  complete;
  logic [ADDR_WIDTH-1:0] acc_word;
  logic [3:0]            acc_sel;
  logic [31:0]           acc_data;
  logic                  acc_we;
  logic                  acc_mis;
  logic                  wr_en;
  logic                  req_mis;

  logic [31:0] mem [0:DEPTH-1];

`ifdef DATA_RAM_ALIGN_CHECK_EN
  // An access is misaligned when its lane mask does not fit the byte offset.
  function automatic logic misaligned(input logic [3:0] sel, input logic [1:0] ofs);
    case (sel)
      4'b1111: return ofs != 2'b00;
      4'b1100: return ofs != 2'b00;
      4'b0011: return ofs != 2'b10;
      4'b1000: return ofs != 2'b00;
      4'b0100: return ofs != 2'b01;
      4'b0010: return ofs != 2'b10;
      4'b0001: return ofs != 2'b11;
      4'b0000: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign req_mis = misaligned(sel_i, addr_i[1:0]);

  // Sticky error flag, set when a misaligned access reaches completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (complete && acc_mis) begin
      err_o <= 1'b1;
    end
  end
`else
  assign req_mis = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Next-state, wait counting, stall request and selection of the completing access.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    latch_en      = 1'b0;
    stall_req_o   = 1'b0;
    complete      = 1'b0;
    acc_word      = addr_i[ADDR_WIDTH+1:2];
    acc_sel       = sel_i;
    acc_data      = data_i;
    acc_we        = we_i;
    acc_mis       = req_mis;
    case (state)
      IDLE: begin
        if (ce_i) begin
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
          end else begin
            stall_req_o   = 1'b1;
            latch_en      = 1'b1;
            wait_cnt_next = WAIT_RELOAD;
            state_next    = (WAIT_CYCLES == 1) ? DONE : WAIT;
          end
        end
      end
      WAIT: begin
        stall_req_o = 1'b1;
        if (!ce_i || (addr_i != lat_addr) || (we_i != lat_we)) begin
          state_next = IDLE;
        end else if (wait_cnt == 4'd0) begin
          state_next = DONE;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      DONE: begin
        complete   = 1'b1;
        acc_word   = lat_addr[ADDR_WIDTH+1:2];
        acc_sel    = lat_sel;
        acc_data   = lat_data;
        acc_we     = lat_we;
        acc_mis    = lat_mis;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (rst) begin
      stall_req_o = 1'b0;
      complete    = 1'b0;
      latch_en    = 1'b0;
    end
  end

  assign wr_en  = complete && acc_we && !acc_mis;
  assign data_o = (complete && !acc_we && !acc_mis) ? mem[acc_word] : 32'h0;

  // State register and wait-state counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Capture the request so the completion cycle uses exactly what was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr <= 32'h0;
      lat_data <= 32'h0;
      lat_sel  <= 4'h0;
      lat_we   <= 1'b0;
      lat_mis  <= 1'b0;
    end else if (latch_en) begin
      lat_addr <= addr_i;
      lat_data <= data_i;
      lat_sel  <= sel_i;
      lat_we   <= we_i;
      lat_mis  <= req_mis;
    end
  end

  // Byte-lane write into the array; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_sel[i]) begin
          mem[acc_word][8*i +: 8] <= acc_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed, table-driven bench for data_ram.
// One instance with two wait states runs the cycle-by-cycle vector table;
// a second instance with zero wait states covers single-cycle access and wrap.
module tb_data_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  = 1'b1;
  logic        ce   = 1'b0;
  logic        we   = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [3:0]  sel  = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  logic        z_ce   = 1'b0;
  logic        z_we   = 1'b0;
  logic [31:0] z_addr = 32'h0;
  logic [3:0]  z_sel  = 4'h0;
  logic [31:0] z_wdata = 32'h0;
  logic [31:0] z_rdata;
  logic        z_stall;
  logic        z_err;

  data_ram #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(wdata), .data_o(rdata), .stall_req_o(stall), .err_o(err)
  );

  data_ram #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .ce_i(z_ce), .we_i(z_we), .addr_i(z_addr), .sel_i(z_sel),
    .data_i(z_wdata), .data_o(z_rdata), .stall_req_o(z_stall), .err_o(z_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic        chk_stall;
    logic        stall;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic r, input logic c, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d, input logic cs,
                        input logic st, input logic [31:0] rd);
    vec_t v;
    v.rst = r; v.ce = c; v.we = w; v.addr = a; v.sel = s; v.data = d;
    v.chk_stall = cs; v.stall = st; v.rdata = rd;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic w, input logic [31:0] a,
                               input logic [3:0] s, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = r; ce = c; we = w; addr = a; sel = s; wdata = d;
  endtask

  task automatic applyZero(input logic c, input logic w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d);
    @(posedge clk);
    #1;
    z_ce = c; z_we = w; z_addr = a; z_sel = s; z_wdata = d;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // three-cycle stalled access helpers (request held until completion)
  task automatic addWrite(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    addVec(0, 1, 1, a, s, d, 1, 1, 32'h0);
    addVec(0, 1, 1, a, s, d, 1, 1, 32'h0);
    addVec(0, 1, 1, a, s, d, 1, 0, 32'h0);
  endtask

  task automatic addRead(input logic [31:0] a, input logic [31:0] exp);
    addVec(0, 1, 0, a, 4'hF, 32'h0, 1, 1, 32'h0);
    addVec(0, 1, 0, a, 4'hF, 32'h0, 1, 1, 32'h0);
    addVec(0, 1, 0, a, 4'hF, 32'h0, 1, 0, exp);
  endtask

  task automatic addIdle();
    addVec(0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;

    // reset (with a request present, which must be ignored) then idle
    addVec(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h0);
    addVec(1, 1, 0, 32'h40, 4'hF, 32'h0, 1, 0, 32'h0);
    addIdle();
    // SW 0x12345678 -> 0x40, then back-to-back LW 0x40
    addWrite(32'h40, 4'hF, 32'h12345678);
    addRead(32'h40, 32'h12345678);
    addIdle();
    // byte lane: clear word, SB lane 2 at 0x41, read back
    addWrite(32'h40, 4'hF, 32'h00000000);
    addWrite(32'h41, 4'b0100, 32'hABABABAB);
    addRead(32'h40, 32'h00AB0000);
    addIdle();
    // known value at 0x80
    addWrite(32'h80, 4'hF, 32'h11223344);
    addIdle();
    // abort by dropping ce in WAIT
    addVec(0, 1, 1, 32'h80, 4'hF, 32'hFFFFFFFF, 1, 1, 32'h0);
    addVec(0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0);
    addIdle();
    addRead(32'h80, 32'h11223344);
    addIdle();
    // reset asserted in DONE discards the write
    addVec(0, 1, 1, 32'h80, 4'hF, 32'hFFFFFFFF, 1, 1, 32'h0);
    addVec(0, 1, 1, 32'h80, 4'hF, 32'hFFFFFFFF, 1, 1, 32'h0);
    addVec(1, 1, 1, 32'h80, 4'hF, 32'hFFFFFFFF, 1, 0, 32'h0);
    addIdle();
    addRead(32'h80, 32'h11223344);
    addIdle();
    // abort by flipping we in WAIT
    addVec(0, 1, 1, 32'h80, 4'hF, 32'hFFFFFFFF, 1, 1, 32'h0);
    addVec(0, 1, 0, 32'h80, 4'hF, 32'h0, 0, 0, 32'h0);
    addIdle();
    addRead(32'h80, 32'h11223344);
    addIdle();
    // address wrap: 0x1080 aliases 0x80
    addWrite(32'h1080, 4'hF, 32'hDEADBEEF);
    addRead(32'h80, 32'hDEADBEEF);
    addIdle();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].data);
      @(negedge clk);
      if (vecs[i].chk_stall)
        checkOutput($sformatf("vec%0d stall", i), {31'b0, stall}, {31'b0, vecs[i].stall});
      checkOutput($sformatf("vec%0d data", i), rdata, vecs[i].rdata);
      checkOutput($sformatf("vec%0d err", i), {31'b0, err}, 32'h0);
    end

    // read latency measured with a bounded wait
    applyStimulus(0, 1, 0, 32'h40, 4'hF, 32'h0);
    cnt = 0;
    @(negedge clk);
    while (stall && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("latency stall cycles", cnt, 32'd2);
    checkOutput("latency read data", rdata, 32'h00AB0000);
    applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0);

    // zero wait states: wrap write then single-cycle reads and byte write
    applyZero(1, 1, 32'h1000, 4'hF, 32'hCAFEBABE);
    @(negedge clk);
    checkOutput("n0 write stall", {31'b0, z_stall}, 32'h0);
    checkOutput("n0 write data", z_rdata, 32'h0);
    applyZero(1, 0, 32'h0, 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("n0 read stall", {31'b0, z_stall}, 32'h0);
    checkOutput("n0 read wrap", z_rdata, 32'hCAFEBABE);
    applyZero(1, 1, 32'h3, 4'b0001, 32'h5A5A5A5A);
    @(negedge clk);
    checkOutput("n0 sb stall", {31'b0, z_stall}, 32'h0);
    applyZero(1, 0, 32'h1000, 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("n0 read after sb", z_rdata, 32'hCAFEBA5A);
    applyZero(0, 0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("n0 idle data", z_rdata, 32'h0);
    checkOutput("n0 err", {31'b0, z_err}, 32'h0);

`ifdef DATA_RAM_ALIGN_CHECK_EN
    // misaligned full-word store: suppressed, err sticky until reset
    applyStimulus(0, 1, 1, 32'h42, 4'hF, 32'hFFFFFFFF);
    @(negedge clk);
    checkOutput("mis stall0", {31'b0, stall}, 32'h1);
    applyStimulus(0, 1, 1, 32'h42, 4'hF, 32'hFFFFFFFF);
    applyStimulus(0, 1, 1, 32'h42, 4'hF, 32'hFFFFFFFF);
    @(negedge clk);
    checkOutput("mis done stall", {31'b0, stall}, 32'h0);
    checkOutput("mis done data", rdata, 32'h0);
    checkOutput("mis done err", {31'b0, err}, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("mis err set", {31'b0, err}, 32'h1);
    applyStimulus(0, 1, 0, 32'h40, 4'hF, 32'h0);
    applyStimulus(0, 1, 0, 32'h40, 4'hF, 32'h0);
    applyStimulus(0, 1, 0, 32'h40, 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("mis word unchanged", rdata, 32'h00AB0000);
    checkOutput("mis err sticky", {31'b0, err}, 32'h1);
    applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("mis err cleared", {31'b0, err}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
